instruction_encoder: RTL
========================

Name: instruction_encoder

Overview:
- Inverse of the instruction field decoders: packs RISC-V R/I/S/B field sets into 32-bit machine instructions.
- Accepts one field set per handshake and presents the registered machine word downstream with an instruction address.
- The address advances by 4 per emitted instruction.
- Used by the bench/loader path to fill instruction memory for the datapath.

Parameters:
WORDSIZE, 64, width of instr_addr and the address counter
SIZE, 32, machine instruction width; only 32 is supported
BASE_ADDR, 0, address assigned to the first instruction after reset or restart

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
restart  input  1  synchronous; flush output stage and reload address counter
in_valid  input  1  field set present
in_ready  output  1  encoder can accept this cycle
fmt  input  2  00=R, 01=I, 10=S, 11=B
op_code  input  7  opcode
funct7  input  7  R-type only
funct3  input  3  funct3
rs1  input  5  rs1
rs2  input  5  R/S/B only
rd  input  5  R/I only
imm  input  13  two's-complement immediate; I/S use [11:0]; B uses [12:1]
out_valid  output  1  machine_instruction valid
out_ready  input  1  downstream accepts
machine_instruction  output  SIZE  encoded word
instr_addr  output  WORDSIZE  address of machine_instruction
encode_error  output  1  one-cycle pulse: rejected field set
error_count  output  8  saturating count of rejected field sets

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, machine_instruction=0, instr_addr=BASE_ADDR, internal next-address counter=BASE_ADDR, encode_error=0, error_count=0.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Accept occurs when in_valid && in_ready && !restart. Encoding is combinational and registered on accept, giving 1-cycle latency from accept to out_valid.
- Output stage is a single register. While out_valid && !out_ready, machine_instruction and instr_addr hold stable.
- Output transfer occurs when out_valid && out_ready. out_valid clears unless a new accept happens in the same cycle, in which case the new word loads (full throughput).
- Encoding:
  - R: funct7|rs2|rs1|funct3|rd|op_code
  - I: imm[11:0]|rs1|funct3|rd|op_code
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op_code
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op_code
  - Fields not used by fmt are ignored.
- Range check:
  - I/S: error if imm[12] != imm[11] (value outside signed 12-bit range).
  - B: error if imm[0]=1 (odd offset).
  - R: never an error.
- On an accepted field set that fails the check:
  - No word is loaded; out_valid follows the transfer rule only.
  - The address counter does not advance.
  - encode_error=1 on the next cycle only.
  - error_count increments, saturating at 255.
- Address: each loaded word takes the current counter value into instr_addr; the counter then advances by 4. It wraps modulo 2^WORDSIZE without a flag.
- restart=1 (synchronous, highest priority after reset):
  - out_valid goes to 0 and the counter goes to BASE_ADDR.
  - Any in_valid that cycle is not accepted; in_ready still reflects the pre-restart state, but no accept occurs.
  - error_count is not cleared.
- Reset asserted mid-transfer discards the pending word immediately.

Test Plan:
- R add x3,x1,x2: fmt=00, op=0110011, f7=0, f3=0, rs1=1, rs2=2, rd=3, out_ready=1 -> next cycle out_valid=1, word=0x002081B3, instr_addr=0.
- S sd x5,8(x2): fmt=10, op=0100011, f3=011, rs1=2, rs2=5, imm=8, sent right after the R case -> word=0x00513423, instr_addr=4.
- B beq x1,x2,-4: fmt=11, op=1100011, f3=0, rs1=1, rs2=2, imm=13'h1FFC -> word=0xFE208EE3, instr_addr=8.
- I with imm=13'h0800 (+2048), then B with imm=3 -> two encode_error pulses, error_count=2, no out_valid, next valid word still gets instr_addr=12.
- Backpressure: out_ready=0 with two back-to-back in_valid -> first accepted, in_ready=0 afterwards, word and address stable for 5 cycles; raise out_ready -> first transfers and second accepted in the same cycle, second appears next cycle at address+4.
- Restart with out_valid=1, out_ready=0 and in_valid=1 -> out_valid=0 next cycle, nothing accepted, next word gets instr_addr=BASE_ADDR. Repeat with rst_n pulsed low mid-stream -> all outputs return to reset values asynchronously, error_count=0.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs RISC-V R/I/S/B field sets into 32-bit machine words and streams them out
// through a single registered output stage, tagging each word with its address.
module instruction_encoder #(
    parameter int unsigned          WORDSIZE  = 64,
    parameter int unsigned          SIZE      = 32,
    parameter logic [WORDSIZE-1:0]  BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          fmt,
    input  logic [6:0]          op_code,
    input  logic [6:0]          funct7,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rd,
    input  logic [12:0]         imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE-1:0]     machine_instruction,
    output logic [WORDSIZE-1:0] instr_addr,
    output logic                encode_error,
    output logic [7:0]          error_count
);

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_S = 2'b10;

    logic [SIZE-1:0]     enc_word;
    logic                enc_err;
    logic                accept;
    logic                load;
    logic                transfer;
    logic [WORDSIZE-1:0] next_addr;

    // Handshake: a beat moves on either side only when valid and ready are both
    // high in the same cycle; in_ready depends on the output stage alone, never on
    // in_valid, and restart suppresses the input beat without changing in_ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !restart;
    assign load     = accept && !enc_err;
    assign transfer = out_valid && out_ready;

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, op_code};
            end
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, op_code};
                enc_err  = imm[12] != imm[11];
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op_code};
                enc_err  = imm[12] != imm[11];
            end
            default: begin
                // B offsets are always even, so imm[0] has no slot in the word.
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op_code};
                enc_err  = imm[0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid           <= 1'b0;
            machine_instruction <= '0;
            instr_addr          <= BASE_ADDR;
            next_addr           <= BASE_ADDR;
            encode_error        <= 1'b0;
            error_count         <= 8'd0;
        end else if (restart) begin
            out_valid    <= 1'b0;
            next_addr    <= BASE_ADDR;
            encode_error <= 1'b0;
        end else begin
            encode_error <= accept && enc_err;
            if (accept && enc_err && error_count != 8'hFF) begin
                error_count <= error_count + 8'd1;
            end
            if (load) begin
                out_valid           <= 1'b1;
                machine_instruction <= enc_word;
                instr_addr          <= next_addr;
                next_addr           <= next_addr + WORDSIZE'(4);
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
